// File: rtl/qspi_rx_packer_if.sv
// Signal bundle between the QSPI sequencer/RX FIFO side and the receive packer.
// The master modport is the controller side; the slave modport is the packer.
interface qspi_rx_packer_if #(
    parameter int CNT_W = 16
) ();
    logic             start_i;
    logic [1:0]       lanes_i;
    logic [CNT_W-1:0] byte_cnt_i;
    logic             abort_i;
    logic             sample_i;
    logic [3:0]       io_i;
    logic             rx_full_i;
    logic             rx_wr_en_o;
    logic [31:0]      rx_wr_data_o;
    logic             stall_o;
    logic             busy_o;
    logic             done_o;
    logic             overflow_o;

    modport master (
        output start_i, lanes_i, byte_cnt_i, abort_i, sample_i, io_i, rx_full_i,
        input  rx_wr_en_o, rx_wr_data_o, stall_o, busy_o, done_o, overflow_o
    );

    modport slave (
        input  start_i, lanes_i, byte_cnt_i, abort_i, sample_i, io_i, rx_full_i,
        output rx_wr_en_o, rx_wr_data_o, stall_o, busy_o, done_o, overflow_o
    );
endinterface

// File: rtl/qspi_rx_packer.sv
// QSPI receive packer: shifts flash IO samples into MSB-first bytes (1/2/4 lanes),
// packs bytes little-endian into 32-bit words and pushes them to the RX FIFO,
// holding one word pending (and raising stall) while the FIFO is full.
module qspi_rx_packer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic            clk,
    input logic            reset,
    qspi_rx_packer_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FLUSH} state_t;

    state_t           state, state_nx;
    logic [1:0]       lanes_q;
    logic [CNT_W-1:0] rem_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [1:0]       byte_idx_q;
    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] pend_data_q;
    logic             pend_q;
    logic             overflow_q;
    logic             zero_done_q;

    logic [3:0]       nbits;
    logic [3:0]       bits_sum;
    logic [7:0]       shift_nx;
    logic [WIDTH-1:0] word_ins;
    logic             cap, byte_done, last_byte, word_done;
    logic             wr_en, accept, start_idle;
    logic             busy, fsm_done;

    // Bits per sample and the shifted byte for the latched lane mode
    always_comb begin
        nbits    = 4'd1;
        shift_nx = {shift_q[6:0], bus.io_i[1]};
        case (lanes_q)
            2'b01: begin
                nbits    = 4'd2;
                shift_nx = {shift_q[5:0], bus.io_i[1:0]};
            end
            2'b10: begin
                nbits    = 4'd4;
                shift_nx = {shift_q[3:0], bus.io_i[3:0]};
            end
            default: ;
        endcase
    end

    assign cap        = (state == SHIFT) && bus.sample_i && !bus.abort_i;
    assign bits_sum   = {1'b0, bit_cnt_q} + nbits;
    assign byte_done  = cap && (bits_sum == 4'd8);
    assign last_byte  = byte_done && (rem_q == CNT_W'(1));
    assign word_done  = byte_done && ((byte_idx_q == 2'd3) || last_byte);
    assign word_ins   = word_q | (WIDTH'(shift_nx) << {byte_idx_q, 3'b000});
    // A write in the same cycle frees the pending slot for the new word.
    assign wr_en      = pend_q && !bus.rx_full_i && !bus.abort_i;
    assign accept     = word_done && (!pend_q || wr_en);
    assign start_idle = (state == IDLE) && bus.start_i && !bus.abort_i;

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // FSM next state, busy and final-word done
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        fsm_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_idle && (bus.byte_cnt_i != '0)) state_nx = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_byte) state_nx = FLUSH;
            end
            FLUSH: begin
                busy     = 1'b1;
                fsm_done = wr_en;
                if (wr_en) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (bus.abort_i) state_nx = IDLE;
    end

    // Bit/byte assembly: lane/count latch at start, shift and pack while sampling
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lanes_q    <= 2'b00;
            rem_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
        end else if (start_idle) begin
            lanes_q    <= (bus.lanes_i == 2'b11) ? 2'b00 : bus.lanes_i;
            rem_q      <= bus.byte_cnt_i;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
        end else if (cap) begin
            shift_q   <= shift_nx;
            bit_cnt_q <= bits_sum[2:0];
            if (byte_done) begin
                rem_q      <= rem_q - CNT_W'(1);
                byte_idx_q <= byte_idx_q + 2'd1;
                word_q     <= word_done ? '0 : word_ins;
            end
        end
    end

    // Pending word slot, sticky overflow and zero-length done pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            overflow_q  <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            zero_done_q <= start_idle && (bus.byte_cnt_i == '0);
            if (bus.abort_i) begin
                pend_q <= 1'b0;
            end else if (accept) begin
                pend_q      <= 1'b1;
                pend_data_q <= word_ins;
            end else if (wr_en) begin
                pend_q <= 1'b0;
            end
            if (word_done && !accept) overflow_q <= 1'b1;
        end
    end

    assign bus.rx_wr_en_o   = wr_en;
    assign bus.rx_wr_data_o = pend_data_q;
    assign bus.stall_o      = pend_q && bus.rx_full_i;
    assign bus.busy_o       = busy;
    assign bus.done_o       = fsm_done || zero_done_q;
    assign bus.overflow_o   = overflow_q;
endmodule
